fetch_debug_ctrl: RTL and testbench
===================================

# fetch_debug_ctrl

Sequencer for the instruction fetch stage. It receives a byte stream from the debug UART and assembles the bytes into 32-bit words. It writes those words into the instruction memory, then runs the fetch/PC datapath in continuous or single-step mode. It sits between the UART receiver and the fetch stage, and drives the fetch stage's stall input and the memory's write port.

## Interface
Parameters:
- LEN, 32, instruction/data word width
- ADDR_W, 11, instruction memory address width (2048 words)
- HALT_WORD, 32'hFFFFFFFF, instruction word that terminates a program load

Ports:
- i_clk  input  1  clock; all state changes on rising edge
- i_rst  input  1  reset, asynchronous, active-low
- i_rx_data  input  8  received byte
- i_rx_valid  input  1  one-cycle strobe; i_rx_data valid
- i_halt_detected  input  1  fetch stage has issued HALT_WORD
- o_mem_wea  output  1  instruction memory write enable
- o_mem_addr  output  ADDR_W  write address
- o_mem_din  output  LEN  write data
- o_flag_stall  output  1  1 = freeze PC and fetch register
- o_load_done  output  1  level; program loaded, cleared on next 'L'
- o_state  output  3  current FSM state code
- o_cycle_count  output  32  enabled execution cycles (see Configuration)

## Operation
Commands are bytes accepted in IDLE or HALT:
- 'L' (0x4C) → LOAD
- 'C' (0x43) → RUN
- 'S' (0x53) → STEP
- 'I' (0x49) in HALT → IDLE

All other bytes are ignored in those states.

States and transitions:
- IDLE: o_flag_stall=1; waits for a command.
- LOAD: 4 bytes per word, MSB first. After the 4th byte, one write pulse at o_mem_addr, then the address increments. If the written word == HALT_WORD, or the address written was 2^ADDR_W-1, the FSM goes to IDLE and sets o_load_done=1. In LOAD, bytes are data only; command bytes are not decoded.
- RUN: o_flag_stall=0 every cycle until i_halt_detected=1, then HALT.
- STEP: o_flag_stall=1 except for exactly one cycle after each 'N' (0x4E). i_halt_detected during that cycle → HALT. 'C' → RUN, 'I' → IDLE.
- HALT: o_flag_stall=1; waits for 'I'.

Other rules:
- Entering LOAD clears the byte counter, o_mem_addr and o_load_done.
- The address does not wrap; LOAD ends at the top word instead.
- i_rx_valid and i_halt_detected in the same cycle in STEP/RUN: halt wins; the byte is dropped.

## Timing
- Reset values:
  - o_flag_stall=1
  - o_mem_wea=0
  - o_mem_addr=0
  - o_mem_din=0
  - o_load_done=0
  - o_state=IDLE (0)
  - o_cycle_count=0
  - byte counter=0
- Reset mid-LOAD discards any partial word. Memory contents are untouched.
- Byte strobe N (4th byte) at edge k → o_mem_wea=1 and o_mem_din/o_mem_addr valid for one cycle after edge k. o_mem_addr increments at edge k+1.
- Command byte at edge k → new state and new o_flag_stall visible after edge k.
- 'N' at edge k → o_flag_stall=0 during cycle k+1 only, back to 1 after edge k+1.
- i_halt_detected at edge k → o_flag_stall=1 after edge k.
- Back-to-back i_rx_valid on consecutive cycles must be accepted without loss.

## Configuration
- FETCH_DBG_CYCLE_COUNT_EN defined:
  - o_cycle_count increments (mod 2^32) on every cycle with o_flag_stall=0.
  - Cleared on entering LOAD and on reset.
  - Holds in HALT.
- Undefined: o_cycle_count is tied to 0 and no counter is synthesized.

## Structure
- Package fetch_debug_pkg holds:
  - state encoding: IDLE=0, LOAD=1, RUN=2, STEP=3, HALT=4
  - command byte constants: CMD_LOAD, CMD_CONT, CMD_STEP, CMD_NEXT, CMD_IDLE
- Sub-module byte_word_assembler: shift register plus 2-bit byte counter. It outputs a one-cycle word_valid with the assembled word, and is cleared by the FSM.

## Test plan
- Reset during LOAD after 2 bytes, then 'L' + 4 bytes 00 00 00 2A → one write: addr 0, din 0x0000002A. Partial word never written.
- 'L', words 0x11111111, 0x22222222, 0xFFFFFFFF → writes at addr 0, 1, 2 with those values. Then state IDLE and o_load_done=1; 0x4C sent as a data byte inside a word is not decoded.
- 'C', then i_halt_detected asserted 10 cycles later → o_flag_stall=0 for exactly 10 cycles, then 1 and state HALT. With the macro defined, o_cycle_count=10.
- 'S', then three 'N' strobes spaced 5 cycles apart → exactly three single-cycle o_flag_stall=0 pulses, each one cycle after its 'N'.
- In STEP, 'N' and i_halt_detected on the same edge → no enable pulse, state HALT. Then 'I' → IDLE.
- 'L' followed by 2048 non-halt words → last write at addr 2047, then IDLE with o_load_done=1. A following 'C' runs.

Source files
------------

// File: rtl/fetch_debug_pkg.sv
// Shared encodings for the fetch debug sequencer: FSM state codes and
// UART command bytes.
package fetch_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_CONT = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_NEXT = 8'h4E;  // 'N'
  localparam logic [7:0] CMD_IDLE = 8'h49;  // 'I'

endpackage

// File: rtl/fetch_debug_ctrl_assembler.sv
// byte_word_assembler: packs four UART bytes (MSB first) into one word and
// raises word_valid_o for exactly one cycle after the fourth byte.
module byte_word_assembler #(
  parameter int LEN = 32
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clr_i,
  input  logic           byte_valid_i,
  input  logic [7:0]     byte_i,
  output logic [LEN-1:0] word_o,
  output logic           word_valid_o
);

  logic [LEN-1:0] shift_q;
  logic [1:0]     cnt_q;
  logic           word_valid_q;

  // Shift in each accepted byte; flag the word when the fourth one lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q      <= '0;
      cnt_q        <= 2'd0;
      word_valid_q <= 1'b0;
    end else if (clr_i) begin
      shift_q      <= '0;
      cnt_q        <= 2'd0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= byte_valid_i && (cnt_q == 2'd3);
      if (byte_valid_i) begin
        shift_q <= {shift_q[LEN-9:0], byte_i};
        cnt_q   <= cnt_q + 2'd1;
      end
    end
  end

  assign word_o       = shift_q;
  assign word_valid_o = word_valid_q;

endmodule

// File: rtl/fetch_debug_ctrl.sv
// fetch_debug_ctrl: UART-driven program loader and run/step sequencer for
// the fetch stage. Optional execution cycle counter enabled by defining
// FETCH_DBG_CYCLE_COUNT_EN.
module fetch_debug_ctrl
  import fetch_debug_pkg::*;
#(
  parameter int             LEN       = 32,
  parameter int             ADDR_W    = 11,
  parameter logic [LEN-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_halt_detected,
  output logic              o_mem_wea,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [LEN-1:0]    o_mem_din,
  output logic              o_flag_stall,
  output logic              o_load_done,
  output logic [2:0]        o_state,
  output logic [31:0]       o_cycle_count
);

  state_e            state_q;
  logic              stall_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q;
  logic              enter_load;
  logic              asm_valid;
  logic [LEN-1:0]    asm_word;
  logic              asm_word_valid;

  // A load command is only decoded from the two command-accepting states.
  assign enter_load = i_rx_valid && (i_rx_data == CMD_LOAD) &&
                      ((state_q == ST_IDLE) || (state_q == ST_HALT));
  assign asm_valid  = i_rx_valid && (state_q == ST_LOAD);

  byte_word_assembler #(.LEN(LEN)) u_asm (
    .clk_i        (i_clk),
    .rst_ni       (i_rst),
    .clr_i        (enter_load),
    .byte_valid_i (asm_valid),
    .byte_i       (i_rx_data),
    .word_o       (asm_word),
    .word_valid_o (asm_word_valid)
  );

  // Main sequencer: state, stall flag, write address and load-done level.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      stall_q <= 1'b1;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          stall_q <= 1'b1;
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: begin
                state_q <= ST_LOAD;
                addr_q  <= '0;
                done_q  <= 1'b0;
              end
              CMD_CONT: begin
                state_q <= ST_RUN;
                stall_q <= 1'b0;
              end
              CMD_STEP: state_q <= ST_STEP;
              CMD_IDLE: state_q <= ST_IDLE;
              default:  ;
            endcase
          end
        end
        ST_LOAD: begin
          stall_q <= 1'b1;
          if (asm_word_valid) begin
            // The top word ends the load rather than wrapping the address.
            if ((asm_word == HALT_WORD) || (addr_q == {ADDR_W{1'b1}})) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (i_halt_detected) begin
            state_q <= ST_HALT;
            stall_q <= 1'b1;
          end else begin
            stall_q <= 1'b0;
          end
        end
        ST_STEP: begin
          stall_q <= 1'b1;
          // A halt always wins over a byte arriving in the same cycle.
          if (i_halt_detected) begin
            state_q <= ST_HALT;
          end else if (i_rx_valid) begin
            case (i_rx_data)
              CMD_NEXT: stall_q <= 1'b0;
              CMD_CONT: begin
                state_q <= ST_RUN;
                stall_q <= 1'b0;
              end
              CMD_IDLE: state_q <= ST_IDLE;
              default:  ;
            endcase
          end
        end
        default: begin
          state_q <= ST_IDLE;
          stall_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_DBG_CYCLE_COUNT_EN
  logic [31:0] cyc_q;

  // Count every cycle the fetch stage is enabled; restart with each load.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cyc_q <= 32'd0;
    end else if (enter_load) begin
      cyc_q <= 32'd0;
    end else if (!stall_q) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign o_cycle_count = cyc_q;
`else
  assign o_cycle_count = 32'd0;
`endif

  assign o_mem_wea    = asm_word_valid;
  assign o_mem_addr   = addr_q;
  assign o_mem_din    = asm_word;
  assign o_flag_stall = stall_q;
  assign o_load_done  = done_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_fetch_debug_ctrl.sv
// Directed, table-driven bench for fetch_debug_ctrl.
module tb_fetch_debug_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_STEP = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

`ifdef FETCH_DBG_CYCLE_COUNT_EN
  localparam int RUN_CYCLES_EXP = 10;
`else
  localparam int RUN_CYCLES_EXP = 0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        i_halt_detected = 1'b0;
  logic        o_mem_wea;
  logic [10:0] o_mem_addr;
  logic [31:0] o_mem_din;
  logic        o_flag_stall;
  logic        o_load_done;
  logic [2:0]  o_state;
  logic [31:0] o_cycle_count;

  fetch_debug_ctrl dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_rx_data       (i_rx_data),
    .i_rx_valid      (i_rx_valid),
    .i_halt_detected (i_halt_detected),
    .o_mem_wea       (o_mem_wea),
    .o_mem_addr      (o_mem_addr),
    .o_mem_din       (o_mem_din),
    .o_flag_stall    (o_flag_stall),
    .o_load_done     (o_load_done),
    .o_state         (o_state),
    .o_cycle_count   (o_cycle_count)
  );

  always #5 i_clk = ~i_clk;

  // Write monitor, sampled mid-cycle.
  int          wr_cnt = 0;
  logic [10:0] wr_addr = '0;
  logic [31:0] wr_din = '0;
  always @(negedge i_clk) begin
    if (o_mem_wea) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= o_mem_addr;
      wr_din  <= o_mem_din;
    end
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        h;
    logic [2:0]  st;
    logic        stall;
    logic        wea;
    logic [10:0] addr;
    logic [31:0] din;
    logic        done;
    logic        chk_cc;
    logic [31:0] cc;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic void add(input logic v, input logic [7:0] d, input logic h,
                              input logic [2:0] st, input logic stall, input logic wea,
                              input logic [10:0] addr, input logic [31:0] din,
                              input logic done, input logic chk_cc = 1'b0,
                              input logic [31:0] cc = 32'd0);
    vec_t t;
    t.v = v; t.d = d; t.h = h; t.st = st; t.stall = stall; t.wea = wea;
    t.addr = addr; t.din = din; t.done = done; t.chk_cc = chk_cc; t.cc = cc;
    vecs.push_back(t);
  endfunction

  function automatic void add_word(input int w, input logic [31:0] word);
    for (int b = 0; b < 4; b++) begin
      logic [7:0] bt;
      bt = word[31-8*b -: 8];
      add(1'b1, bt, 1'b0, S_LOAD, 1'b1, (b == 3), w[10:0], word, 1'b0);
    end
  endfunction

  // One clock edge with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic h);
    i_rx_valid = v;
    i_rx_data = d;
    i_halt_detected = h;
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
    i_halt_detected = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " state"}, {29'd0, o_state}, {29'd0, S_IDLE});
    chk({tag, " stall"}, {31'd0, o_flag_stall}, 32'd1);
    chk({tag, " wea"}, {31'd0, o_mem_wea}, 32'd0);
    chk({tag, " addr"}, {21'd0, o_mem_addr}, 32'd0);
    chk({tag, " din"}, o_mem_din, 32'd0);
    chk({tag, " done"}, {31'd0, o_load_done}, 32'd0);
    chk({tag, " cycles"}, o_cycle_count, 32'd0);
  endtask

  initial begin
    logic [31:0] words [4];
    int          base;
    int          errs;
    logic [31:0] w;

    // ---- Reset values ----
    repeat (3) @(posedge i_clk);
    #1;
    chk_reset_vals("por");
    i_rst = 1'b1;
    idle(1);

    // ---- Reset mid-load discards the partial word ----
    base = wr_cnt;
    send(8'h4C);
    send(8'hAA);
    send(8'hBB);
    i_rst = 1'b0;
    #1;
    chk_reset_vals("midload_rst");
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    send(8'h4C);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    send(8'h2A);
    chk("rl wea", {31'd0, o_mem_wea}, 32'd1);
    idle(1);
    chk("rl addr_inc", {21'd0, o_mem_addr}, 32'd1);
    chk("rl write_count", wr_cnt - base, 32'd1);
    chk("rl write_addr", {21'd0, wr_addr}, 32'd0);
    chk("rl write_din", wr_din, 32'h0000002A);
    $display("txn reset-mid-load: writes=%0d addr=%0d din=%h", wr_cnt - base, wr_addr, wr_din);
    i_rst = 1'b0;
    #1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;

    // ---- Vector table: load, run, step, halt ----
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    words[2] = 32'h4C4C4C4C;
    words[3] = 32'hFFFFFFFF;
    add(1'b1, 8'h4C, 1'b0, S_LOAD, 1'b1, 1'b0, 11'd0, 32'd0, 1'b0);
    for (int k = 0; k < 4; k++) add_word(k, words[k]);
    add(1'b0, 8'h00, 1'b0, S_IDLE, 1'b1, 1'b0, 11'd0, 32'd0, 1'b1);
    add(1'b1, 8'h58, 1'b0, S_IDLE, 1'b1, 1'b0, 11'd0, 32'd0, 1'b1);
    add(1'b1, 8'h43, 1'b0, S_RUN, 1'b0, 1'b0, 11'd0, 32'd0, 1'b1);
    for (int k = 0; k < 9; k++) add(1'b0, 8'h00, 1'b0, S_RUN, 1'b0, 1'b0, 11'd0, 32'd0, 1'b1);
    add(1'b0, 8'h00, 1'b1, S_HALT, 1'b1, 1'b0, 11'd0, 32'd0, 1'b1, 1'b1, RUN_CYCLES_EXP);
    add(1'b0, 8'h00, 1'b0, S_HALT, 1'b1, 1'b0, 11'd0, 32'd0, 1'b1, 1'b1, RUN_CYCLES_EXP);
    add(1'b1, 8'h4E, 1'b0, S_HALT, 1'b1, 1'b0, 11'd0, 32'd0, 1'b1);
    add(1'b1, 8'h49, 1'b0, S_IDLE, 1'b1, 1'b0, 11'd0, 32'd0, 1'b1);
    add(1'b1, 8'h53, 1'b0, S_STEP, 1'b1, 1'b0, 11'd0, 32'd0, 1'b1);
    for (int p = 0; p < 3; p++) begin
      add(1'b1, 8'h4E, 1'b0, S_STEP, 1'b0, 1'b0, 11'd0, 32'd0, 1'b1);
      for (int k = 0; k < 4; k++) add(1'b0, 8'h00, 1'b0, S_STEP, 1'b1, 1'b0, 11'd0, 32'd0, 1'b1);
    end
    add(1'b1, 8'h4E, 1'b1, S_HALT, 1'b1, 1'b0, 11'd0, 32'd0, 1'b1);
    add(1'b1, 8'h49, 1'b0, S_IDLE, 1'b1, 1'b0, 11'd0, 32'd0, 1'b1);

    base = wr_cnt;
    foreach (vecs[i]) begin
      cyc(vecs[i].v, vecs[i].d, vecs[i].h);
      $display("txn vec %0d: v=%0d d=%h h=%0d -> state=%0d stall=%0d wea=%0d addr=%0d din=%h done=%0d",
               i, vecs[i].v, vecs[i].d, vecs[i].h, o_state, o_flag_stall, o_mem_wea,
               o_mem_addr, o_mem_din, o_load_done);
      chk($sformatf("v%0d state", i), {29'd0, o_state}, {29'd0, vecs[i].st});
      chk($sformatf("v%0d stall", i), {31'd0, o_flag_stall}, {31'd0, vecs[i].stall});
      chk($sformatf("v%0d wea", i), {31'd0, o_mem_wea}, {31'd0, vecs[i].wea});
      chk($sformatf("v%0d done", i), {31'd0, o_load_done}, {31'd0, vecs[i].done});
      if (vecs[i].st == S_LOAD)
        chk($sformatf("v%0d addr", i), {21'd0, o_mem_addr}, {21'd0, vecs[i].addr});
      if (vecs[i].wea)
        chk($sformatf("v%0d din", i), o_mem_din, vecs[i].din);
      if (vecs[i].chk_cc)
        chk($sformatf("v%0d cycles", i), o_cycle_count, vecs[i].cc);
    end
    chk("table write_count", wr_cnt - base, 32'd4);

    // ---- Full-memory load: ends at the top word ----
    base = wr_cnt;
    errs = 0;
    send(8'h4C);
    chk("full state", {29'd0, o_state}, {29'd0, S_LOAD});
    chk("full done_cleared", {31'd0, o_load_done}, 32'd0);
    chk("full cycles_cleared", o_cycle_count, 32'd0);
    for (int i = 0; i < 2048; i++) begin
      w = 32'h5A000000 + i;
      for (int b = 0; b < 4; b++) send(w[31-8*b -: 8]);
      if (!(o_mem_wea === 1'b1 && o_mem_addr === i[10:0] && o_mem_din === w)) begin
        errs++;
        $display("txn full word %0d: wea=%0d addr=%0d din=%h (unexpected)", i, o_mem_wea, o_mem_addr, o_mem_din);
      end else if (i % 256 == 0 || i == 2047) begin
        $display("txn full word %0d: addr=%0d din=%h", i, o_mem_addr, o_mem_din);
      end
    end
    idle(1);
    chk("full word_errors", errs, 32'd0);
    chk("full write_count", wr_cnt - base, 32'd2048);
    chk("full last_addr", {21'd0, wr_addr}, 32'd2047);
    chk("full end_state", {29'd0, o_state}, {29'd0, S_IDLE});
    chk("full end_done", {31'd0, o_load_done}, 32'd1);
    send(8'h43);
    chk("full run_state", {29'd0, o_state}, {29'd0, S_RUN});
    chk("full run_stall", {31'd0, o_flag_stall}, 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("full halt_state", {29'd0, o_state}, {29'd0, S_HALT});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
